// File: rtl/cgra_config_pkg.sv
// Shared types for the CGRA configuration receiver: address field layout,
// load-tracking FSM states and the decoded configuration word.
package cgra_config_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TILE_LSB    = 0;
    localparam int FEATURE_LSB = 16;
    localparam int REG_LSB     = 24;
    localparam int TILE_W      = 16;
    localparam int FEATURE_W   = 8;
    localparam int REG_W       = 8;

    typedef enum logic [1:0] {IDLE, LOADING, DRAIN, DONE} cfg_state_t;

    // "reg" is a keyword, so the register field is called reg_id
    typedef struct packed {
        logic [TILE_W-1:0]    tile;
        logic [FEATURE_W-1:0] feature;
        logic [REG_W-1:0]     reg_id;
        logic [DATA_W-1:0]    data;
    } cfg_word_t;

    // Pure bit slicing of the address; no arithmetic on any field
    function automatic cfg_word_t decode_word(input logic [ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0] data);
        cfg_word_t w;
        w.tile    = addr[TILE_LSB +: TILE_W];
        w.feature = addr[FEATURE_LSB +: FEATURE_W];
        w.reg_id  = addr[REG_LSB +: REG_W];
        w.data    = data;
        return w;
    endfunction

endpackage

// File: rtl/cgra_config_fifo.sv
// Show-ahead FIFO of decoded configuration words. The head entry is always
// visible on dout; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module cgra_config_fifo
    import cgra_config_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  cfg_word_t din,
    input  logic      pop,
    output cfg_word_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cfg_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cgra_config_rx.sv
// Configuration-port receiver: samples the host address/data stream, decodes
// nonzero-address writes, buffers them and issues them on the tile config bus.
// Tracks the configuration load and flags completion after a run of idle cycles.
module cgra_config_rx
    import cgra_config_pkg::*;
#(
    parameter int NUM_TILES  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_DONE  = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] config_addr_in,
    input  logic [DATA_W-1:0] config_data_in,
    output logic              cfg_valid_out,
    input  logic              cfg_ready_in,
    output logic [15:0]       cfg_tile_out,
    output logic [7:0]        cfg_feature_out,
    output logic [7:0]        cfg_reg_out,
    output logic [31:0]       cfg_data_out,
    output logic              config_done_out,
    output logic [15:0]       write_count_out,
    output logic              err_overflow_out,
    output logic              err_bad_tile_out
);

    localparam int CW = $clog2(IDLE_DONE + 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_DONE);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_DONE - 1);
    localparam logic [16:0]   TILE_LIMIT = 17'(NUM_TILES);

    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_vld;
    cfg_word_t         in_word;
    logic              tile_ok;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    cfg_word_t         head;
    cfg_state_t        state;
    logic [CW-1:0]     idle_cnt;

    // Input register: one word sampled every cycle, no backpressure
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            in_addr <= '0;
            in_data <= '0;
            in_vld  <= 1'b0;
        end else begin
            in_addr <= config_addr_in;
            in_data <= config_data_in;
            in_vld  <= (config_addr_in != '0);
        end
    end

    assign in_word = decode_word(in_addr, in_data);
    assign tile_ok = ({1'b0, in_word.tile} < TILE_LIMIT);
    assign push    = in_vld && tile_ok;
    assign pop     = cfg_valid_out && cfg_ready_in;

    cgra_config_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (push),
        .din   (in_word),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cfg_valid_out   = !fifo_empty;
    assign cfg_tile_out    = head.tile;
    assign cfg_feature_out = head.feature;
    assign cfg_reg_out     = head.reg_id;
    assign cfg_data_out    = head.data;

    // Sticky error flags and saturating transfer counter
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            err_bad_tile_out <= 1'b0;
            err_overflow_out <= 1'b0;
            write_count_out  <= '0;
        end else begin
            if (in_vld && !tile_ok)            err_bad_tile_out <= 1'b1;
            if (push && fifo_full && !pop)     err_overflow_out <= 1'b1;
            if (pop && write_count_out != 16'hFFFF)
                write_count_out <= write_count_out + 16'd1;
        end
    end

    // Load-tracking FSM; any registered nonzero address (even a rejected one) is activity
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= IDLE;
            idle_cnt        <= '0;
            config_done_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        state    <= LOADING;
                        idle_cnt <= '0;
                    end
                end
                LOADING: begin
                    if (in_vld) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= IDLE_MAX;
                        state    <= DRAIN;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (in_vld) begin
                        state    <= LOADING;
                        idle_cnt <= '0;
                    end else if (fifo_empty) begin
                        state           <= DONE;
                        config_done_out <= 1'b1;
                    end
                end
                DONE: begin
                    if (in_vld) begin
                        state           <= LOADING;
                        idle_cnt        <= '0;
                        config_done_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_rx.sv
// Directed bench for cgra_config_rx: expected tile-bus words are queued as
// writes are driven and compared by a monitor as each transfer happens.
module tb_cgra_config_rx;
    import cgra_config_pkg::*;

    logic        clk_in;
    logic        reset_in;
    logic [31:0] config_addr_in;
    logic [31:0] config_data_in;
    logic        cfg_valid_out;
    logic        cfg_ready_in;
    logic [15:0] cfg_tile_out;
    logic [7:0]  cfg_feature_out;
    logic [7:0]  cfg_reg_out;
    logic [31:0] cfg_data_out;
    logic        config_done_out;
    logic [15:0] write_count_out;
    logic        err_overflow_out;
    logic        err_bad_tile_out;

    int n_assert = 0;
    int n_fail   = 0;
    cfg_word_t exp_q[$];
    cfg_word_t mon_e;

    cgra_config_rx dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .config_addr_in   (config_addr_in),
        .config_data_in   (config_data_in),
        .cfg_valid_out    (cfg_valid_out),
        .cfg_ready_in     (cfg_ready_in),
        .cfg_tile_out     (cfg_tile_out),
        .cfg_feature_out  (cfg_feature_out),
        .cfg_reg_out      (cfg_reg_out),
        .cfg_data_out     (cfg_data_out),
        .config_done_out  (config_done_out),
        .write_count_out  (write_count_out),
        .err_overflow_out (err_overflow_out),
        .err_bad_tile_out (err_bad_tile_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic cfg_word_t mk(input logic [31:0] a, input logic [31:0] d);
        cfg_word_t w;
        w.tile    = a[15:0];
        w.feature = a[23:16];
        w.reg_id  = a[31:24];
        w.data    = d;
        return w;
    endfunction

    // Drive one write for one cycle, then return the port to idle
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit expect_xfer);
        if (expect_xfer) exp_q.push_back(mk(a, d));
        config_addr_in = a;
        config_data_in = d;
        tick();
        config_addr_in = '0;
        config_data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (cfg_valid_out && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, cfg_valid_out, 0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready here
    always @(negedge clk_in) begin
        if (!reset_in && cfg_valid_out && cfg_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_tile",    32'(cfg_tile_out),    32'(mon_e.tile));
                chk("xfer_feature", 32'(cfg_feature_out), 32'(mon_e.feature));
                chk("xfer_reg",     32'(cfg_reg_out),     32'(mon_e.reg_id));
                chk("xfer_data",    cfg_data_out,         mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_in = 1'b1;
        config_addr_in = '0;
        config_data_in = '0;
        cfg_ready_in = 1'b0;
        #12;
        chk("rst_valid",   cfg_valid_out, 0);
        chk("rst_done",    config_done_out, 0);
        chk("rst_count",   32'(write_count_out), 0);
        chk("rst_ovf",     err_overflow_out, 0);
        chk("rst_bad",     err_bad_tile_out, 0);
        chk("rst_tile",    32'(cfg_tile_out), 0);
        chk("rst_data",    cfg_data_out, 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        tick();

        // Single write: visible two edges after being driven
        cfg_ready_in = 1'b1;
        wr(32'h0201_0005, 32'hDEAD_BEEF, 1);
        tick();
        chk("single_valid",   cfg_valid_out, 1);
        chk("single_tile",    32'(cfg_tile_out), 32'h5);
        chk("single_feature", 32'(cfg_feature_out), 32'h1);
        chk("single_reg",     32'(cfg_reg_out), 32'h2);
        chk("single_data",    cfg_data_out, 32'hDEAD_BEEF);
        tick();
        chk("single_count", 32'(write_count_out), 1);
        chk("single_gone",  cfg_valid_out, 0);

        // Stall with 6 writes: 4 buffered, 2 dropped
        do_reset();
        cfg_ready_in = 1'b0;
        for (int i = 1; i <= 6; i++)
            wr({8'h03, 8'h07, 16'(i)}, 32'hA000_0000 + 32'(i), i <= 4);
        tick();
        tick();
        chk("stall_ovf",   err_overflow_out, 1);
        chk("stall_valid", cfg_valid_out, 1);
        chk("stall_tile",  32'(cfg_tile_out), 32'h1);
        tick();
        tick();
        tick();
        chk("stall_hold_tile", 32'(cfg_tile_out), 32'h1);
        chk("stall_hold_data", cfg_data_out, 32'hA000_0001);
        cfg_ready_in = 1'b1;
        drain("stall");
        chk("stall_count", 32'(write_count_out), 4);

        // Full FIFO with simultaneous pop: nothing dropped
        do_reset();
        cfg_ready_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) cfg_ready_in = 1'b1;
            if (i >= 7) chk("fullpop_valid", cfg_valid_out, 1);
            wr({8'h11, 8'h22, 16'(i + 16)}, 32'h5500_0000 + 32'(i), 1);
        end
        drain("fullpop");
        chk("fullpop_ovf",   err_overflow_out, 0);
        chk("fullpop_count", 32'(write_count_out), 12);

        // Bad tile ids rejected, boundary tile 255 accepted
        do_reset();
        cfg_ready_in = 1'b1;
        wr(32'h0000_0100, 32'h1234_5678, 0);
        wr(32'h0102_FFFF, 32'h8765_4321, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bad_no_valid", cfg_valid_out, 0);
            tick();
        end
        chk("bad_flag",  err_bad_tile_out, 1);
        chk("bad_count", 32'(write_count_out), 0);
        chk("bad_ovf",   err_overflow_out, 0);
        wr(32'h0403_00FF, 32'hCAFE_F00D, 1);
        tick();
        drain("edge_tile");
        chk("edge_tile_count", 32'(write_count_out), 1);
        chk("bad_sticky",      err_bad_tile_out, 1);

        // Done detection after a run of idle cycles
        do_reset();
        cfg_ready_in = 1'b1;
        wr(32'h0001_0001, 32'h0000_0011, 1);
        wr(32'h0001_0002, 32'h0000_0022, 1);
        wr(32'h0001_0003, 32'h0000_0033, 1);
        n = 0;
        while (!config_done_out && n < 40) begin
            chk("done_early_empty_wait", 32'(n < 8 ? config_done_out : 1'b0), 0);
            tick();
            n++;
        end
        chk("done_rise",     config_done_out, 1);
        chk("done_delay_ok", 32'(n >= 8 && n <= 12), 1);
        chk("done_empty",    cfg_valid_out, 0);
        chk("done_count",    32'(write_count_out), 3);
        chk("done_sb_empty", 32'(exp_q.size()), 0);

        // Reconfigure: done drops one cycle after the write is registered
        wr(32'h0002_0004, 32'h0000_0044, 1);
        chk("reconf_done_still", config_done_out, 1);
        tick();
        chk("reconf_done_drop", config_done_out, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("gap7_done", config_done_out, 0);
        end
        wr(32'h0002_0005, 32'h0000_0055, 1);
        for (int i = 0; i < 3; i++) begin
            chk("gap7_after_done", config_done_out, 0);
            tick();
        end
        n = 0;
        while (!config_done_out && n < 40) begin
            tick();
            n++;
        end
        chk("redone_rise",  config_done_out, 1);
        chk("redone_count", 32'(write_count_out), 5);

        // Reconfigure write, then asynchronous reset mid-cycle
        cfg_ready_in = 1'b0;
        wr(32'h0009_0007, 32'h7777_7777, 0);
        tick();
        chk("midload_valid", cfg_valid_out, 1);
        #3;
        reset_in = 1'b1;
        #1;
        chk("arst_valid", cfg_valid_out, 0);
        chk("arst_tile",  32'(cfg_tile_out), 0);
        chk("arst_feat",  32'(cfg_feature_out), 0);
        chk("arst_reg",   32'(cfg_reg_out), 0);
        chk("arst_data",  cfg_data_out, 0);
        chk("arst_done",  config_done_out, 0);
        chk("arst_count", 32'(write_count_out), 0);
        chk("arst_ovf",   err_overflow_out, 0);
        chk("arst_bad",   err_bad_tile_out, 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        cfg_ready_in = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("post_rst_empty", cfg_valid_out, 0);
        chk("post_rst_idle",  config_done_out, 0);
        chk("post_rst_count", 32'(write_count_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
